// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-bit input front-end for raw gpio pins.
// Each bit is synchronised through two flops and debounced by a counter.
// The block then produces a debounced level, one-cycle rise/fall pulses and a
// sticky, write-1-to-clear interrupt status. irq_out is the OR of all status bits.
module gpio_in_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             bb_clk_in,
    input  logic             bb_rst_n_in,
    input  logic [WIDTH-1:0] bb_gpio_in,
    input  logic [WIDTH-1:0] irq_en_in,
    input  logic [WIDTH-1:0] irq_clr_in,
    output logic [WIDTH-1:0] gpio_level_out,
    output logic [WIDTH-1:0] gpio_rise_out,
    output logic [WIDTH-1:0] gpio_fall_out,
    output logic [WIDTH-1:0] irq_status_out,
    output logic             irq_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state logic: synchroniser shift, per-bit debounce, edge pulses, sticky status
    always_comb begin
        s1_d         = bb_gpio_in;
        s2_d         = s1_q;
        level_d      = level_q;
        rise_d       = '0;
        fall_d       = '0;
        irq_status_d = irq_status_q;
        cnt_d        = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // A new enabled event takes priority over a clear on the same edge
            if ((rise_d[i] || fall_d[i]) && irq_en_in[i]) begin
                irq_status_d[i] = 1'b1;
            end else if (irq_clr_in[i]) begin
                irq_status_d[i] = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge bb_clk_in or negedge bb_rst_n_in) begin
        if (!bb_rst_n_in) begin
            s1_q         <= '0;
            s2_q         <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            irq_status_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            irq_status_q <= irq_status_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gpio_level_out = level_q;
    assign gpio_rise_out  = rise_q;
    assign gpio_fall_out  = fall_q;
    assign irq_status_out = irq_status_q;
    assign irq_out        = |irq_status_q;

endmodule
